// File: rtl/serial_gp_adder_pkg.sv
// Shared constants for the bit-serial group generate/propagate adder:
// FSM state encoding and the default operand width.
package serial_gp_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/serial_gp_adder_if.sv
// Operand/result handshake bundle of the serial adder. The slave side is the
// adder; the master side is whoever supplies operands and consumes results.
interface serial_gp_adder_if
    import serial_gp_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             group_g;
    logic             group_p;

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, group_g, group_p
    );

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, group_g, group_p
    );

endinterface

// File: rtl/serial_gp_adder_fa.sv
// Single-bit full adder cell that also exposes its generate/propagate terms
// for carry-lookahead consumers.
module full_adder_gp (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o,
    output logic g_o,
    output logic p_o
);

    assign g_o = a_i & b_i;
    assign p_o = a_i ^ b_i;
    assign s_o = p_o ^ c_i;
    assign c_o = g_o | (p_o & c_i);

endmodule

// File: rtl/serial_gp_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder_gp cell processes one bit per
// cycle, LSB first, while the per-bit G/P terms are folded into group G/P.
module serial_gp_adder
    import serial_gp_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_gp_adder_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             gacc_q, gacc_d;
    logic             pacc_q, pacc_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s, fa_c, fa_g, fa_p;

    full_adder_gp u_fa (
        .a_i (a_q[cnt_q]),
        .b_i (b_q[cnt_q]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c),
        .g_o (fa_g),
        .p_o (fa_p)
    );

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves a signal unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        gacc_d  = gacc_q;
        pacc_d  = pacc_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_d = ST_RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    gacc_d  = 1'b0;
                    pacc_d  = 1'b1;
                    sum_d   = '0;
                end
            end
            ST_RUN: begin
                sum_d[cnt_q] = fa_s;
                carry_d      = fa_c;
                gacc_d       = fa_g | (fa_p & gacc_q);
                pacc_d       = fa_p & pacc_q;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    // carry_q here is the carry into the MSB
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            gacc_q  <= 1'b0;
            pacc_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            gacc_q  <= gacc_d;
            pacc_q  <= pacc_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.group_g   = gacc_q;
    assign bus.group_p   = pacc_q;

endmodule

// File: tb/tb_serial_gp_adder.sv
// Self-checking bench: an 8-bit and a 3-bit adder are compared every cycle
// against an arithmetic model of a+b+cin and its group generate/propagate.
module tb_serial_gp_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        gg;
        logic        gp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_gp_adder_if #(.WIDTH(8)) bus8 ();
    serial_gp_adder_if #(.WIDTH(3)) bus3 ();

    serial_gp_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_gp_adder #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    exp_t q8[$];
    exp_t q3[$];
    exp_t h8, h3;
    logic busy8 = 1'b0, busy3 = 1'b0;
    logic seen8 = 1'b0, seen3 = 1'b0;
    int   acc8 = 0, acc3 = 0;
    int   done3 = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected result from plain integer arithmetic on w-bit operands.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b, input logic cin);
        exp_t r;
        logic [63:0] mask, full, nocin;
        mask   = (64'd1 << w) - 64'd1;
        full   = {32'd0, a} + {32'd0, b} + {63'd0, cin};
        nocin  = {32'd0, a} + {32'd0, b};
        r.sum  = full[31:0] & mask[31:0];
        r.cout = full[w];
        r.ovf  = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
        r.gg   = nocin[w];
        r.gp   = (({32'd0, a ^ b}) & mask) == mask;
        return r;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q8.delete(); busy8 = 1'b0; seen8 = 1'b0;
        end else begin
            check("in_ready8", bus8.in_ready, !busy8);
            if (bus8.out_valid) begin
                if (q8.size() == 0) begin
                    check("spurious_out_valid8", bus8.out_valid, 1'b0);
                end else begin
                    h8 = q8[0];
                    if (!seen8) begin
                        check("latency8", cyc - acc8 - 1, 8);
                        seen8 = 1'b1;
                    end
                    check("sum8", bus8.sum, h8.sum);
                    check("cout8", bus8.cout, h8.cout);
                    check("ovf8", bus8.ovf, h8.ovf);
                    check("group_g8", bus8.group_g, h8.gg);
                    check("group_p8", bus8.group_p, h8.gp);
                    if (bus8.out_ready) begin
                        void'(q8.pop_front());
                        busy8 = 1'b0; seen8 = 1'b0;
                    end
                end
            end
            if (bus8.in_valid && bus8.in_ready) begin
                q8.push_back(model(8, {24'd0, bus8.a}, {24'd0, bus8.b}, bus8.cin));
                busy8 = 1'b1; acc8 = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q3.delete(); busy3 = 1'b0; seen3 = 1'b0;
        end else begin
            check("in_ready3", bus3.in_ready, !busy3);
            if (bus3.out_valid) begin
                if (q3.size() == 0) begin
                    check("spurious_out_valid3", bus3.out_valid, 1'b0);
                end else begin
                    h3 = q3[0];
                    if (!seen3) begin
                        check("latency3", cyc - acc3 - 1, 3);
                        seen3 = 1'b1;
                    end
                    check("sum3", bus3.sum, h3.sum);
                    check("cout3", bus3.cout, h3.cout);
                    check("ovf3", bus3.ovf, h3.ovf);
                    check("group_g3", bus3.group_g, h3.gg);
                    check("group_p3", bus3.group_p, h3.gp);
                    if (bus3.out_ready) begin
                        void'(q3.pop_front());
                        busy3 = 1'b0; seen3 = 1'b0; done3++;
                    end
                end
            end
            if (bus3.in_valid && bus3.in_ready) begin
                q3.push_back(model(3, {29'd0, bus3.a}, {29'd0, bus3.b}, bus3.cin));
                busy3 = 1'b1; acc3 = cyc;
            end
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int n = 0;
        @(posedge clk); #1;
        bus8.in_valid = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
        @(negedge clk);
        while (!bus8.in_ready && n < 100) begin @(negedge clk); n++; end
        if (!bus8.in_ready) check("in_ready_timeout8", bus8.in_ready, 1'b1);
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
    endtask

    task automatic wait_valid8();
        int n = 0;
        @(negedge clk);
        while (!bus8.out_valid && n < 100) begin @(negedge clk); n++; end
        if (!bus8.out_valid) check("out_valid_timeout8", bus8.out_valid, 1'b1);
    endtask

    task automatic recv8(input int hold);
        wait_valid8();
        repeat (hold) @(negedge clk);
        @(posedge clk); #1 bus8.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 bus8.out_ready = 1'b0;
    endtask

    task automatic check_res8(input string nm, input logic [7:0] s, input logic c, input logic o,
                              input logic g, input logic p);
        check({nm, "_sum"}, bus8.sum, s);
        check({nm, "_cout"}, bus8.cout, c);
        check({nm, "_ovf"}, bus8.ovf, o);
        check({nm, "_gg"}, bus8.group_g, g);
        check({nm, "_gp"}, bus8.group_p, p);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0; bus8.out_ready = 1'b0;
        bus3.in_valid = 1'b0; bus3.a = '0; bus3.b = '0; bus3.cin = 1'b0; bus3.out_ready = 1'b1;

        #1;
        check("rst_in_ready", bus8.in_ready, 1'b1);
        check("rst_out_valid", bus8.out_valid, 1'b0);
        check_res8("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        send8(8'h5A, 8'h3C, 1'b0); recv8(0);
        check_res8("basic", 8'h96, 1'b0, 1'b1, 1'b0, 1'b0);
        send8(8'hFF, 8'h00, 1'b1); recv8(0);
        check_res8("propagate", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        send8(8'h80, 8'h80, 1'b0); recv8(0);
        check_res8("generate", 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

        // Backpressure: result must sit still and no operand may be taken.
        send8(8'hC3, 8'h5E, 1'b0);
        wait_valid8();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus8.in_valid = ~bus8.in_valid;
            bus8.a = 8'($urandom); bus8.b = 8'($urandom);
            @(negedge clk);
            check("hold_out_valid", bus8.out_valid, 1'b1);
            check("hold_in_ready", bus8.in_ready, 1'b0);
            check_res8("hold", 8'h21, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        // Release together with a new operand: it is taken one cycle later.
        @(posedge clk); #1;
        bus8.out_ready = 1'b1; bus8.in_valid = 1'b1;
        bus8.a = 8'h7F; bus8.b = 8'h01; bus8.cin = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 bus8.out_ready = 1'b0;
        @(negedge clk);
        check("release_out_valid", bus8.out_valid, 1'b0);
        check("release_in_ready", bus8.in_ready, 1'b1);
        @(posedge clk); #1 bus8.in_valid = 1'b0;
        recv8(0);
        check_res8("late_accept", 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous abort with cnt=3.
        send8(8'h0F, 8'h03, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_in_ready", bus8.in_ready, 1'b1);
        check("abort_out_valid", bus8.out_valid, 1'b0);
        check_res8("abort", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        send8(8'h01, 8'h01, 1'b0); recv8(0);
        check_res8("after_abort", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            send8(8'($urandom), 8'($urandom), 1'($urandom));
            recv8(int'($urandom_range(0, 3)));
        end
        check("drain8", q8.size(), 0);

        // Exhaustive WIDTH=3, back-to-back with the consumer always ready.
        for (int i = 0; i < 128; i++) begin
            logic [6:0] v;
            int n;
            v = 7'(i);
            @(posedge clk); #1;
            bus3.in_valid = 1'b1; bus3.a = v[6:4]; bus3.b = v[3:1]; bus3.cin = v[0];
            n = 0;
            @(negedge clk);
            while (!bus3.in_ready && n < 100) begin @(negedge clk); n++; end
            if (!bus3.in_ready) check("in_ready_timeout3", bus3.in_ready, 1'b1);
        end
        @(posedge clk); #1 bus3.in_valid = 1'b0;
        for (int n = 0; n < 100 && q3.size() != 0; n++) @(negedge clk);
        check("drain3", q3.size(), 0);
        check("count3", done3, 128);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
